// File: rtl/kuantalama_pkg.sv
// kuantalama_pkg: shared constants for the 8x8 dequantizer -- block size,
// index width and the 64-entry 8-bit luminance quantization table (raster order).
package kuantalama_pkg;
  localparam int BLK_N = 64;
  localparam int IDX_W = 6;
  localparam logic [0:BLK_N-1][7:0] LUMA_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };
endpackage

// File: rtl/ters_kuantalama_tablo.sv
// ters_kuantalama_tablo: registered quantization-table read, one-cycle latency.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i pipeline advance
// (the read register holds while stalled); addr_i 6-bit raster index; q_o 8-bit table value.
module ters_kuantalama_tablo
  import kuantalama_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [IDX_W-1:0] addr_i,
  output logic [7:0]       q_o
);
  logic [7:0] q_d, q_q;
  always_comb q_d = en_i ? LUMA_Q[addr_i] : q_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/ters_kuantalama.sv
// ters_kuantalama: two-stage streaming 8x8 dequantizer, m_data = s_data * Q[index].
// Ports: clk_i/rst_ni clock and async active-low reset; s_valid_i/s_ready_o/s_data_i
// input coefficient handshake (raster order); m_valid_o/m_ready_i/m_data_o output
// handshake with m_index_o raster index and m_last_o at index 63; sat_o clip flag.
// Build option: TERS_KUANTALAMA_SAT_EN selects saturating output (else wrap, sat_o=0).
module ters_kuantalama
  import kuantalama_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic signed [IN_W-1:0]  s_data_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic signed [OUT_W-1:0] m_data_o,
  output logic [IDX_W-1:0]        m_index_o,
  output logic                    m_last_o,
  output logic                    sat_o
);
  logic                    en;
  logic [IDX_W-1:0]        idx_d, idx_q, s1_idx_d, s1_idx_q, m_index_d, m_index_q;
  logic                    s1_valid_d, s1_valid_q, m_valid_d, m_valid_q, m_last_d, m_last_q;
  logic signed [IN_W-1:0]  s1_data_d, s1_data_q;
  logic signed [OUT_W-1:0] m_data_d, m_data_q;
  logic signed [IN_W+7:0]  prod;
  logic [7:0]              q_tab;
`ifdef TERS_KUANTALAMA_SAT_EN
  localparam logic signed [IN_W+7:0] P_MAX = (IN_W+8)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [IN_W+7:0] P_MIN = ~P_MAX;
  logic sat_d, sat_q;
`endif

  assign en = !m_valid_q || m_ready_i;

  // Table address is the index of the coefficient being accepted, so its
  // registered output lines up with stage 1.
  ters_kuantalama_tablo u_tablo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en),
    .addr_i (idx_q),
    .q_o    (q_tab)
  );

  always_comb begin
    idx_d      = (s_valid_i && en) ? idx_q + 1'b1 : idx_q;
    s1_valid_d = en ? s_valid_i : s1_valid_q;
    s1_data_d  = en ? s_data_i : s1_data_q;
    s1_idx_d   = en ? idx_q : s1_idx_q;
    // Q is zero-extended so it multiplies as an unsigned 8-bit magnitude.
    prod       = $signed((IN_W+8)'(s1_data_q)) * $signed((IN_W+8)'(q_tab));
    m_valid_d  = en ? s1_valid_q : m_valid_q;
    m_index_d  = en ? s1_idx_q : m_index_q;
    m_last_d   = en ? (s1_valid_q && s1_idx_q == IDX_W'(BLK_N-1)) : m_last_q;
`ifdef TERS_KUANTALAMA_SAT_EN
    m_data_d   = !en ? m_data_q : prod > P_MAX ? OUT_W'(P_MAX) : prod < P_MIN ? OUT_W'(P_MIN) : OUT_W'(prod);
    sat_d      = en ? (s1_valid_q && (prod > P_MAX || prod < P_MIN)) : sat_q;
`else
    m_data_d   = en ? OUT_W'(prod) : m_data_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_idx_q   <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_index_q  <= '0;
      m_last_q   <= 1'b0;
`ifdef TERS_KUANTALAMA_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      idx_q      <= idx_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_idx_q   <= s1_idx_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_index_q  <= m_index_d;
      m_last_q   <= m_last_d;
`ifdef TERS_KUANTALAMA_SAT_EN
      sat_q      <= sat_d;
`endif
    end

  assign s_ready_o = en;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_index_o = m_index_q;
  assign m_last_o  = m_last_q;
`ifdef TERS_KUANTALAMA_SAT_EN
  assign sat_o     = sat_q;
`else
  assign sat_o     = 1'b0;
`endif
endmodule

// File: tb/tb_ters_kuantalama.sv
// tb_ters_kuantalama: directed and randomized checks of ters_kuantalama against a queue-based reference model.
module tb_ters_kuantalama;
  logic        clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic        s_ready, m_valid, m_last, sat;
  logic [11:0] s_data = '0;
  logic [15:0] m_data;
  logic [5:0]  m_index;

  always #5 clk = ~clk;

  ters_kuantalama dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_index_o (m_index),
    .m_last_o  (m_last),
    .sat_o     (sat)
  );

  int tbl [64] = '{16, 11, 10, 16, 24, 40, 51, 61,
                   12, 12, 14, 19, 26, 58, 60, 55,
                   14, 13, 16, 24, 40, 57, 69, 56,
                   14, 17, 22, 29, 51, 87, 80, 62,
                   18, 22, 37, 56, 68, 109, 103, 77,
                   24, 35, 55, 64, 81, 104, 113, 92,
                   49, 64, 78, 87, 103, 121, 120, 101,
                   72, 92, 95, 98, 112, 100, 103, 99};

  typedef struct {int d; int idx; int cyc;} ent_t;
  ent_t q[$];
  int n_chk = 0, n_pass = 0;
  int mdl_idx = 0, cyc = 0, last_stall = -10, outs = 0, lasts = 0;
  bit prev_stall = 0, after_rst = 1;
  logic [15:0] pd;
  logic [5:0]  pi;
  logic        pl, ps;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int expect_val(input int d, input int idx, output int s);
    int p;
    p = d * tbl[idx];
    s = 0;
`ifdef TERS_KUANTALAMA_SAT_EN
    if (p > 32767) begin p = 32767; s = 1; end
    else if (p < -32768) begin p = -32768; s = 1; end
`else
    p = p & 32'hFFFF;
    if (p > 32767) p = p - 65536;
`endif
    return p;
  endfunction

  always @(negedge clk) begin
    ent_t e;
    int ev, es;
    cyc++;
    if (!rst_n) begin
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_index", m_index, 0);
      check("rst_m_last", m_last, 0);
      check("rst_sat", sat, 0);
      check("rst_s_ready", s_ready, 1);
      q.delete();
      mdl_idx = 0;
      prev_stall = 0;
      after_rst = 1;
    end else begin
      check("s_ready", s_ready, int'(!m_valid || m_ready));
      check("last_flag", m_last, int'(m_valid && m_index == 6'd63));
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, pd);
        check("hold_index", m_index, pi);
        check("hold_last", m_last, pl);
        check("hold_sat", sat, ps);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) check("spurious_out", q.size(), 1);
        else begin
          e = q.pop_front();
          ev = expect_val(e.d, e.idx, es);
          check("data", $signed(m_data), ev);
          check("index", m_index, e.idx);
          check("sat", sat, es);
          if (last_stall < e.cyc) check("latency", cyc - e.cyc, 2);
          if (after_rst) begin
            check("idx_after_rst", m_index, 0);
            after_rst = 0;
          end
        end
        outs++;
        if (m_last) lasts++;
      end
      if (m_valid && !m_ready) last_stall = cyc;
      prev_stall = m_valid && !m_ready;
      pd = m_data; pi = m_index; pl = m_last; ps = sat;
      if (s_valid && s_ready) begin
        q.push_back('{$signed(s_data), mdl_idx, cyc});
        mdl_idx = (mdl_idx + 1) % 64;
      end
    end
  end

  task automatic send(input int d);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data = 12'(d);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", int'(ok), 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    m_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !m_valid) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int o0, l0;
    bit acc;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    l0 = lasts; o0 = outs;
    for (int i = 0; i < 64; i++) send(1);
    drain();
    check("ones_outs", outs - o0, 64);
    check("ones_lasts", lasts - l0, 1);
    for (int i = 0; i < 64; i++) send(i == 53 ? 2047 : 0);
    drain();
    send(-2048);
    while (mdl_idx != 0) send(int'($urandom_range(0, 4095)) - 2048);
    drain();
    o0 = outs;
    send(5); send(-7); send(100);
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_ready", s_ready, 0);
      check("stall_valid", m_valid, 1);
    end
    @(posedge clk); #1;
    drain();
    check("stall_outs", outs - o0, 3);
    while (mdl_idx != 21) send(int'($urandom_range(0, 4095)) - 2048);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    l0 = lasts; o0 = outs;
    for (int i = 0; i < 128; i++) send(int'($urandom_range(0, 4095)) - 2048);
    drain();
    check("stream_outs", outs - o0, 128);
    check("stream_lasts", lasts - l0, 2);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (!s_valid || acc) begin
        s_valid = $urandom_range(0, 3) != 0;
        s_data = 12'($urandom);
      end
      m_ready = $urandom_range(0, 2) != 0;
    end
    s_valid = 1'b0;
    drain();
    check("final_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
